// File: rtl/pipe_stage_buffer.sv
// -----------------------------------------------------------------------------
// pipe_stage_buffer
//   Valid/ready pipeline stage holding up to DEPTH payloads.
//     DEPTH = 1 : plain stage register; in_ready is combinational
//                 (!out_valid || out_ready), so back-to-back transfers run at
//                 full rate.
//     DEPTH = 2 : skid buffer; in_ready comes straight from a flop, which
//                 removes the combinational out_ready -> in_ready path.
//   A synchronous flush kills every held payload and any payload accepted on
//   the same edge. flushed_cnt reports how many were killed.
//
// Ports
//   clk          rising-edge clock
//   reset        asynchronous active-high reset
//   in_valid     upstream offers in_data
//   in_ready     stage can accept this cycle
//   in_data      upstream payload [DATA_W]
//   out_valid    stage presents out_data
//   out_ready    downstream accepts this cycle
//   out_data     head payload [DATA_W]
//   flush        synchronous kill of held and incoming payloads
//   occupancy    registered count of held payloads (0..DEPTH)
//   flushed_cnt  payloads discarded by the most recent flush (saturates at 3)
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module pipe_stage_buffer #(
  parameter int DATA_W = 102,
  parameter int DEPTH  = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  input  logic              flush,
  output logic [1:0]        occupancy,
  output logic [1:0]        flushed_cnt
);

  if (DEPTH != 1 && DEPTH != 2) begin : g_bad_depth
    $error("pipe_stage_buffer: DEPTH must be 1 or 2");
  end

  localparam bit SKID = (DEPTH == 2);

  // Storage: main entry drives the outputs, skid entry catches the payload
  // that arrives while main is stalled (DEPTH = 2 only).
  logic              r_main_valid;
  logic [DATA_W-1:0] r_main_data;
  logic              r_skid_valid;
  logic [DATA_W-1:0] r_skid_data;
  logic              r_in_ready;
  logic [1:0]        r_occupancy;
  logic [1:0]        r_flushed_cnt;

  logic              w_accept;
  logic              w_deliver;
  logic              w_main_valid_nxt;
  logic              w_skid_valid_nxt;
  logic              w_main_load;
  logic              w_main_from_skid;
  logic              w_skid_load;
  logic [2:0]        w_kill_cnt;

  // With DEPTH = 1 the main entry may be replaced on the same edge it is
  // delivered, hence the out_ready term.
  assign in_ready    = SKID ? r_in_ready : (!r_main_valid || out_ready);
  assign out_valid   = r_main_valid;
  assign out_data    = r_main_data;
  assign occupancy   = r_occupancy;
  assign flushed_cnt = r_flushed_cnt;

  // NOTE: every signal written here gets a default first, so no path through
  // the block leaves a value unassigned and no latch is inferred.
  always_comb begin
    w_accept         = in_valid && in_ready;
    w_deliver        = r_main_valid && out_ready;
    w_main_valid_nxt = r_main_valid;
    w_skid_valid_nxt = r_skid_valid;
    w_main_load      = 1'b0;
    w_main_from_skid = 1'b0;
    w_skid_load      = 1'b0;

    if (r_skid_valid) begin
      // in_ready is low here, so nothing new arrives; only a shift can happen.
      if (w_deliver) begin
        w_main_from_skid = 1'b1;
        w_skid_valid_nxt = 1'b0;
      end
    end else if (r_main_valid && !w_deliver) begin
      // Main is stalled: an accepted payload parks in the skid entry. For
      // DEPTH = 1 in_ready is low in this state, so the skid stays empty.
      if (w_accept) begin
        w_skid_load      = 1'b1;
        w_skid_valid_nxt = 1'b1;
      end
    end else begin
      // Empty or draining: the new payload (if any) goes straight to main.
      w_main_load      = w_accept;
      w_main_valid_nxt = w_accept;
    end

    // Payloads alive just before a flush edge: held entries not being
    // delivered plus any payload accepted on that edge.
    w_kill_cnt = {2'b00, r_main_valid} + {2'b00, r_skid_valid}
               + {2'b00, w_accept} - {2'b00, w_deliver};
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_main_valid  <= 1'b0;
      r_skid_valid  <= 1'b0;
      r_in_ready    <= 1'b1;
      r_occupancy   <= 2'd0;
      r_flushed_cnt <= 2'd0;
      // NOTE: the payload registers are cleared on reset as well, so out_data
      // reads a defined zero out of reset rather than stale contents.
      r_main_data   <= '0;
      r_skid_data   <= '0;
    end else begin
      // Data registers move only on accept or shift; flush leaves them alone.
      if (w_main_from_skid) begin
        r_main_data <= r_skid_data;
      end else if (w_main_load) begin
        r_main_data <= in_data;
      end
      if (w_skid_load) begin
        r_skid_data <= in_data;
      end

      if (flush) begin
        r_main_valid  <= 1'b0;
        r_skid_valid  <= 1'b0;
        r_in_ready    <= 1'b1;
        r_occupancy   <= 2'd0;
        r_flushed_cnt <= (w_kill_cnt > 3'd3) ? 2'd3 : w_kill_cnt[1:0];
      end else begin
        r_main_valid <= w_main_valid_nxt;
        r_skid_valid <= w_skid_valid_nxt;
        r_in_ready   <= !w_skid_valid_nxt;
        r_occupancy  <= {1'b0, w_main_valid_nxt} + {1'b0, w_skid_valid_nxt};
      end
    end
  end

endmodule
